// File: rtl/rdma_rx_data_pool.sv
// rdma_rx_data_pool
//  Receive payload pool between DDP and the DMA write engine. Rdmap reserves a
//  run of entries, DDP fills reserved entries in order, and the DMA engine
//  drains filled entries in order.
//
//  Three ADDR_W+1 bit pointers split the ring into three regions:
//    [rdPtr, wrPtr)    filled entries waiting to be drained
//    [wrPtr, resvPtr)  reserved entries not yet written by DDP
//    [resvPtr, rdPtr)  free entries
//
//  Optional feature: define POOL_STATS_EN to add the saturating drop/nack
//  counters dropCnt and nackCnt.
//
//  Ports
//    clock, reset          single clock, synchronous active-high reset
//    bufRegister/rgstrNum  reservation request and entry count (0 = no-op)
//    rgstrAck/rgstrNack    reservation granted / refused (1-cycle pulses)
//    rgstrPtr/lastNum      first/last entry index of last granted reservation
//    push/pushData         DDP beat write
//    pushErr               beat dropped, nothing reserved (1-cycle pulse)
//    popReq                drain request
//    popValid/popData      drained beat, one cycle after popReq
//    poolEmpty/poolFull    no filled entries / no free entries
//    dropCnt/nackCnt       (POOL_STATS_EN only) saturating event counters
module rdma_rx_data_pool #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bufRegister,
  input  logic [2:0]        rgstrNum,
  output logic              rgstrAck,
  output logic              rgstrNack,
  output logic [ADDR_W-1:0] rgstrPtr,
  output logic [ADDR_W-1:0] lastNum,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  output logic              pushErr,
  input  logic              popReq,
  output logic              popValid,
  output logic [DATA_W-1:0] popData,
`ifdef POOL_STATS_EN
  output logic [15:0]       dropCnt,
  output logic [15:0]       nackCnt,
`endif
  output logic              poolEmpty,
  output logic              poolFull
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]  wrPtr, rdPtr, resvPtr;
  logic [PTR_W-1:0]  wrPtrNxt, rdPtrNxt, resvPtrNxt;
  logic [PTR_W-1:0]  filled, pending, used, freeCnt, reqCnt;
  logic              reqValid, doResv, doNack, doPush, doDrop, doPop;
  logic [DATA_W-1:0] mem [DEPTH];

  // Request decode; every decision uses pre-edge pointers, so a pop never
  // frees space for a same-cycle reservation and a same-cycle grant never
  // covers a same-cycle push.
  always_comb begin
    filled     = wrPtr - rdPtr;
    pending    = resvPtr - wrPtr;
    used       = resvPtr - rdPtr;
    freeCnt    = PTR_W'(DEPTH) - used;
    reqCnt     = PTR_W'(rgstrNum);
    reqValid   = bufRegister && (rgstrNum != 3'd0);
    doResv     = reqValid && (reqCnt <= freeCnt);
    doNack     = reqValid && (reqCnt > freeCnt);
    doPush     = push && (pending != '0);
    doDrop     = push && (pending == '0);
    doPop      = popReq && (filled != '0);
    resvPtrNxt = doResv ? resvPtr + reqCnt : resvPtr;
    wrPtrNxt   = doPush ? wrPtr + PTR_W'(1) : wrPtr;
    rdPtrNxt   = doPop ? rdPtr + PTR_W'(1) : rdPtr;
  end

  // Pointers, pulses, reservation window and flags (flags from post-edge pointers).
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      resvPtr   <= '0;
      rgstrPtr  <= '0;
      lastNum   <= '0;
      rgstrAck  <= 1'b0;
      rgstrNack <= 1'b0;
      pushErr   <= 1'b0;
      popValid  <= 1'b0;
      popData   <= '0;
      poolEmpty <= 1'b1;
      poolFull  <= 1'b0;
    end else begin
      wrPtr     <= wrPtrNxt;
      rdPtr     <= rdPtrNxt;
      resvPtr   <= resvPtrNxt;
      rgstrAck  <= doResv;
      rgstrNack <= doNack;
      pushErr   <= doDrop;
      popValid  <= doPop;
      if (doResv) begin
        rgstrPtr <= resvPtr[ADDR_W-1:0];
        lastNum  <= ADDR_W'(resvPtr + reqCnt - PTR_W'(1));
      end
      if (doPop) begin
        popData <= mem[rdPtr[ADDR_W-1:0]];
      end
      poolEmpty <= (wrPtrNxt == rdPtrNxt);
      poolFull  <= ((resvPtrNxt - rdPtrNxt) == PTR_W'(DEPTH));
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrPtr[ADDR_W-1:0]] <= pushData;
    end
  end

`ifdef POOL_STATS_EN
  // Saturating drop / refusal counters for Rdmap diagnostics.
  always_ff @(posedge clock) begin
    if (reset) begin
      dropCnt <= '0;
      nackCnt <= '0;
    end else begin
      if (doDrop && (dropCnt != 16'hFFFF)) begin
        dropCnt <= dropCnt + 16'd1;
      end
      if (doNack && (nackCnt != 16'hFFFF)) begin
        nackCnt <= nackCnt + 16'd1;
      end
    end
  end
`endif

endmodule
